// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared encodings and defaults for the multiplier share arbiter
package mult_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_BLANK = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int WIDTH_DEFAULT   = 3;
   localparam int TIMEOUT_DEFAULT = 16;
   localparam int CW_DEFAULT      = 5;

   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
   import mult_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   // Under contention the requester that was not served last wins.
   always_comb begin
      gnt_valid = |req;
      if (req == 2'b11)
         gnt_idx = ~last;
      else if (req[REQ1])
         gnt_idx = REQ1;
      else
         gnt_idx = REQ0;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one start/done multiplier core between two requesters
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CW      = CW_DEFAULT
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           req,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic [1:0]           ack,
   output logic [1:0]           rsp_valid,
   output logic [2*WIDTH-1:0]   rsp_product,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic                 mul_start,
   input  logic                 mul_done,
   input  logic [2*WIDTH-1:0]   mul_product
);

   state_t          state, state_next;
   logic            owner;
   logic            last;
   logic [CW-1:0]   cnt;
   logic            gnt_valid;
   logic            gnt_idx;
   logic            expired;

   rr_pick2 u_pick (
      .req       (req),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign expired = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (gnt_valid) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_BLANK;
         ST_BLANK: state_next = ST_WAIT;
         ST_WAIT:  if (mul_done || expired) state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered on the transition into the state that presents them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner       <= REQ0;
         last        <= REQ1;
         cnt         <= '0;
         ack         <= 2'b00;
         rsp_valid   <= 2'b00;
         rsp_product <= '0;
         rsp_err     <= 1'b0;
         busy        <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         mul_start   <= 1'b0;
      end else begin
         ack       <= 2'b00;
         rsp_valid <= 2'b00;
         mul_start <= 1'b0;
         busy      <= (state_next != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  owner     <= gnt_idx;
                  mul_a     <= gnt_idx ? a1 : a0;
                  mul_b     <= gnt_idx ? b1 : b0;
                  mul_start <= 1'b1;
                  ack       <= idx_onehot(gnt_idx);
                  cnt       <= '0;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 1'b1;
               if (mul_done) begin
                  rsp_product <= mul_product;
                  rsp_err     <= 1'b0;
                  rsp_valid   <= idx_onehot(owner);
               end else if (expired) begin
                  rsp_product <= '0;
                  rsp_err     <= 1'b1;
                  rsp_valid   <= idx_onehot(owner);
               end
            end
            ST_RESP: begin
               last        <= owner;
               rsp_err     <= 1'b0;
               rsp_product <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;

   localparam int WIDTH   = 3;
   localparam int TIMEOUT = 16;
   localparam int CW      = 5;
   localparam int CORE_LAT = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          req = 2'b00;
   logic [WIDTH-1:0]    a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [1:0]          ack, rsp_valid;
   logic [2*WIDTH-1:0]  rsp_product;
   logic                rsp_err, busy, mul_start;
   logic [WIDTH-1:0]    mul_a, mul_b;
   logic                mul_done = 1'b0;
   logic [2*WIDTH-1:0]  mul_product = '0;

   int n_pass = 0;
   int n_total = 0;

   logic             m_last = 1'b1;
   logic [WIDTH-1:0] op_a [2];
   logic [WIDTH-1:0] op_b [2];

   bit no_done = 0;
   bit stale_mode = 0;
   int core_k = -1;
   logic [2*WIDTH-1:0] core_p = '0;

   mult_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .req         (req),
      .a0          (a0),
      .b0          (b0),
      .a1          (a1),
      .b1          (b1),
      .ack         (ack),
      .rsp_valid   (rsp_valid),
      .rsp_product (rsp_product),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_start   (mul_start),
      .mul_done    (mul_done),
      .mul_product (mul_product)
   );

   always #5 clk = ~clk;

   // Core model: done level rises CORE_LAT negedges after start and stays up until the next start.
   always @(negedge clk) begin
      if (mul_start === 1'b1) begin
         core_k = 0;
         core_p = {3'b000, mul_a} * {3'b000, mul_b};
         if (!stale_mode) mul_done = 1'b0;
      end else if (core_k >= 0) begin
         core_k++;
         if (stale_mode && core_k == 2) mul_done = 1'b0;
         if (core_k == CORE_LAT && !no_done) begin
            mul_done    = 1'b1;
            mul_product = core_p;
            core_k      = -1;
         end
      end
   end

   function automatic logic [1:0] oh(input logic i);
      return i ? 2'b10 : 2'b01;
   endfunction

   task automatic set_ops(input logic i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      if (i) begin a1 = a; b1 = b; end
      else   begin a0 = a; b0 = b; end
   endtask

   task automatic serve(input int n_jobs, input bit rereq, input bit expect_err, input string tag);
      int jobs = 0;
      int cyc = 0;
      int ack_cyc = 0;
      logic own = 1'b0;
      bit have = 0;
      bit chk_idle = 0;
      logic [2*WIDTH-1:0] exp_p;
      while (jobs < n_jobs && cyc < 300) begin
         @(negedge clk);
         cyc++;
         n_total++;
         if ((ack !== 2'b00 && rsp_valid !== 2'b00) || mul_start !== (ack !== 2'b00))
            $display("FAIL %s handshake ack=%b rsp_valid=%b mul_start=%b required exclusive, start with ack", tag, ack, rsp_valid, mul_start);
         else n_pass++;
         if (chk_idle) begin
            chk_idle = 0;
            n_total++;
            if (busy !== 1'b0 || ack !== 2'b00)
               $display("FAIL %s idle_gap busy=%b ack=%b required busy=0 ack=00", tag, busy, ack);
            else n_pass++;
         end
         if (ack !== 2'b00) begin
            own = (req == 2'b11) ? ~m_last : req[1];
            n_total++;
            if (have || ack !== oh(own) || busy !== 1'b1 || mul_a !== op_a[own] || mul_b !== op_b[own])
               $display("FAIL %s grant ack=%b busy=%b mul_a=%0d mul_b=%0d required ack=%b busy=1 mul_a=%0d mul_b=%0d",
                        tag, ack, busy, mul_a, mul_b, oh(own), op_a[own], op_b[own]);
            else n_pass++;
            have = 1;
            ack_cyc = cyc;
            req[own] = 1'b0;
         end
         if (rsp_valid !== 2'b00) begin
            exp_p = expect_err ? '0 : {3'b000, op_a[own]} * {3'b000, op_b[own]};
            n_total++;
            if (!have || rsp_valid !== oh(own) || rsp_product !== exp_p || rsp_err !== expect_err)
               $display("FAIL %s response rsp_valid=%b product=%0d err=%b required rsp_valid=%b product=%0d err=%b",
                        tag, rsp_valid, rsp_product, rsp_err, oh(own), exp_p, expect_err);
            else n_pass++;
            if (expect_err) begin
               n_total++;
               if (cyc - ack_cyc != TIMEOUT + 2)
                  $display("FAIL %s watchdog_latency got=%0d required=%0d", tag, cyc - ack_cyc, TIMEOUT + 2);
               else n_pass++;
            end
            m_last = own;
            have = 0;
            jobs++;
            chk_idle = 1;
            if (jobs >= n_jobs) req = 2'b00;
            else if (rereq) begin
               set_ops(own, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
               req[own] = 1'b1;
            end
         end
      end
      n_total++;
      if (jobs < n_jobs) begin
         $display("FAIL %s job_budget served=%0d required=%0d", tag, jobs, n_jobs);
         req = 2'b00;
      end else n_pass++;
   endtask

   task automatic check_all_zero(input string tag);
      n_total++;
      if (ack !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0 || mul_start !== 1'b0 ||
          busy !== 1'b0 || mul_a !== '0 || mul_b !== '0 || rsp_product !== '0)
         $display("FAIL %s outputs ack=%b rsp_valid=%b err=%b start=%b busy=%b a=%0d b=%0d p=%0d required all 0",
                  tag, ack, rsp_valid, rsp_err, mul_start, busy, mul_a, mul_b, rsp_product);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset_idle");
      m_last = 1'b1;
   endtask

   task automatic test_contention();
      set_ops(1'b0, 3'd3, 3'd7);
      set_ops(1'b1, 3'd7, 3'd7);
      req = 2'b11;
      serve(2, 0, 0, "contention");
   endtask

   task automatic test_single();
      set_ops(1'b0, 3'd5, 3'd6);
      req = 2'b01;
      serve(1, 0, 0, "single");
   endtask

   task automatic test_fairness();
      set_ops(1'b0, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
      set_ops(1'b1, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
      req = 2'b11;
      serve(6, 1, 0, "fairness");
   endtask

   task automatic test_watchdog();
      no_done = 1;
      set_ops(1'b1, WIDTH'($urandom_range(1, 7)), WIDTH'($urandom_range(1, 7)));
      req = 2'b10;
      serve(1, 0, 1, "watchdog");
      no_done = 0;
      set_ops(1'b1, 3'd7, 3'd7);
      req = 2'b10;
      serve(1, 0, 0, "after_watchdog");
   endtask

   task automatic test_stale_done();
      stale_mode = 1;
      set_ops(1'b1, 3'd0, 3'd7);
      req = 2'b10;
      serve(1, 0, 0, "stale_done");
      stale_mode = 0;
      set_ops(1'b0, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
      req = 2'b01;
      serve(1, 0, 0, "after_stale");
   endtask

   task automatic test_reset_mid_wait();
      bit seen = 0;
      bit quiet = 1;
      no_done = 1;
      set_ops(1'b0, 3'd6, 3'd5);
      req = 2'b01;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (ack !== 2'b00) seen = 1;
      end
      req = 2'b00;
      n_total++;
      if (!seen) $display("FAIL mid_wait_ack ack=%b required 01 within 10 cycles", ack);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      no_done = 0;
      core_k = -1;
      mul_done = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00 || busy !== 1'b0) quiet = 0;
      end
      n_total++;
      if (!quiet) $display("FAIL abandoned_job rsp_valid=%b busy=%b required no response", rsp_valid, busy);
      else n_pass++;
      set_ops(1'b0, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
      set_ops(1'b1, WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
      req = 2'b11;
      serve(1, 0, 0, "post_reset_grant");
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_fairness();
      test_watchdog();
      test_stale_done();
      test_reset_mid_wait();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit passed=%0d total=%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
